// File: rtl/i_buf_ds_rx_deser.sv
// Differential pad receiver: buffer, 2-FF sync, glitch filter, LSB-first frame
// deserializer (start, WIDTH data, stop) and invalid-pair (I_P==I_N) monitor.
module i_buf_ds_rx_deser #(
   parameter int WIDTH     = 8,
   parameter int BIT_CYC   = 16,
   parameter int FILT      = 3,
   parameter int ERR_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             I_P,
   input  logic             I_N,
   input  logic             en,
   input  logic             start,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             line_err,
   output logic [15:0]      edge_cnt
);

   localparam int CW = $clog2(BIT_CYC) + 1;
   localparam int BW = $clog2(WIDTH) + 1;
   localparam int FW = 3;
   localparam int EW = 4;

   typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;

   state_t           state_reg, state_next;
   logic             buf_o;
   logic             s1_reg, s2_reg;
   logic             p1_reg, p2_reg, n1_reg, n2_reg;
   logic [FW-1:0]    filt_cnt_reg;
   logic             filt_reg;
   logic             filt_flip, filt_fall;
   logic [EW-1:0]    run_reg;
   logic             line_set;
   logic [CW-1:0]    cyc_reg;
   logic [BW-1:0]    bit_cnt_reg;
   logic [WIDTH-1:0] shift_reg, shift_in;
   logic [WIDTH-1:0] data_out_reg;
   logic             data_valid_reg, frame_err_reg, line_err_reg;
   logic [15:0]      edge_cnt_reg;
   logic             tick_half, tick_full, last_bit;
   logic             clr_err, shift_en, stop_ok, stop_bad, cnt_run;

   // I_BUF_DS behaviour: the positive leg passes through while enabled, output low when disabled
   assign buf_o = en ? I_P : 1'b0;

   // Level syncs idle high; the raw N leg idles low so the pair looks valid out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_reg <= 1'b1;
         s2_reg <= 1'b1;
         p1_reg <= 1'b1;
         p2_reg <= 1'b1;
         n1_reg <= 1'b0;
         n2_reg <= 1'b0;
      end else begin
         s1_reg <= buf_o;
         s2_reg <= s1_reg;
         p1_reg <= I_P;
         p2_reg <= p1_reg;
         n1_reg <= I_N;
         n2_reg <= n1_reg;
      end
   end

   assign filt_flip = (s2_reg != filt_reg) && (filt_cnt_reg == FW'(FILT - 1));
   assign filt_fall = filt_flip && filt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         filt_reg     <= 1'b1;
         filt_cnt_reg <= '0;
         edge_cnt_reg <= '0;
      end else begin
         if (s2_reg == filt_reg) begin
            filt_cnt_reg <= '0;
         end else if (filt_flip) begin
            filt_reg     <= s2_reg;
            filt_cnt_reg <= '0;
         end else begin
            filt_cnt_reg <= filt_cnt_reg + FW'(1);
         end
         if (filt_flip) edge_cnt_reg <= edge_cnt_reg + 16'd1;
      end
   end

   assign line_set = (p2_reg == n2_reg) && (run_reg == EW'(ERR_LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         run_reg <= '0;
      end else if (p2_reg != n2_reg) begin
         run_reg <= '0;
      end else if (run_reg != EW'(ERR_LIMIT)) begin
         run_reg <= run_reg + EW'(1);
      end
   end

   assign tick_half = (cyc_reg == CW'(BIT_CYC / 2 - 1));
   assign tick_full = (cyc_reg == CW'(BIT_CYC - 1));
   assign last_bit  = (bit_cnt_reg == BW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (!en) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:  if (start) state_next = ARM;
            ARM:   if (filt_fall) state_next = START;
            START: if (tick_half) state_next = filt_reg ? ARM : DATA;
            DATA:  if (tick_full && last_bit) state_next = STOP;
            STOP:  if (tick_full) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      busy     = (state_reg != IDLE);
      clr_err  = en && start && (state_reg == IDLE);
      shift_en = en && (state_reg == DATA) && tick_full;
      stop_ok  = en && (state_reg == STOP) && tick_full && filt_reg;
      stop_bad = en && (state_reg == STOP) && tick_full && !filt_reg;
      cnt_run  = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
   end

   generate
      if (WIDTH == 1) begin : g_shift_one
         assign shift_in = filt_reg;
      end else begin : g_shift_many
         assign shift_in = {filt_reg, shift_reg[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_reg        <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         data_out_reg   <= '0;
         data_valid_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         line_err_reg   <= 1'b0;
      end else begin
         if ((state_next != state_reg) || shift_en) cyc_reg <= '0;
         else if (cnt_run)                          cyc_reg <= cyc_reg + CW'(1);

         if (state_reg == ARM) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
         end else if (shift_en) begin
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
            shift_reg   <= shift_in;
         end

         data_valid_reg <= stop_ok;
         if (stop_ok) data_out_reg <= shift_reg;

         // A same-cycle set beats the start-pulse clear
         if (stop_bad)     frame_err_reg <= 1'b1;
         else if (clr_err) frame_err_reg <= 1'b0;
         if (line_set)     line_err_reg  <= 1'b1;
         else if (clr_err) line_err_reg  <= 1'b0;
      end
   end

   assign data_out   = data_out_reg;
   assign data_valid = data_valid_reg;
   assign frame_err  = frame_err_reg;
   assign line_err   = line_err_reg;
   assign edge_cnt   = edge_cnt_reg;

endmodule

// File: tb/tb_i_buf_ds_rx_deser.sv
// Self-checking bench for i_buf_ds_rx_deser: scoreboard of expected words popped
// on data_valid, plus per-scenario inline checks.
module tb_i_buf_ds_rx_deser;

   localparam int WIDTH     = 8;
   localparam int BIT_CYC   = 16;
   localparam int FILT      = 3;
   localparam int ERR_LIMIT = 4;

   logic             clk = 1'b0;
   logic             rst, I_P, I_N, en, start;
   logic [WIDTH-1:0] data_out;
   logic             data_valid, busy, frame_err, line_err;
   logic [15:0]      edge_cnt;

   int               checks = 0;
   int               errors = 0;
   logic [7:0]       exp_q[$];
   logic [7:0]       exp_word;
   int               exp_edges = 0;
   logic             cur_lvl = 1'b1;

   i_buf_ds_rx_deser #(
      .WIDTH(WIDTH), .BIT_CYC(BIT_CYC), .FILT(FILT), .ERR_LIMIT(ERR_LIMIT)
   ) dut (
      .clk(clk), .rst(rst), .I_P(I_P), .I_N(I_N), .en(en), .start(start),
      .data_out(data_out), .data_valid(data_valid), .busy(busy),
      .frame_err(frame_err), .line_err(line_err), .edge_cnt(edge_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard side: every data_valid must match the oldest expected word
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: data_out=%h, required no data_valid", data_out);
         end else begin
            exp_word = exp_q.pop_front();
            if (data_out !== exp_word) begin
               errors++;
               $display("FAIL rx_word: data_out=%h, required %h", data_out, exp_word);
            end else begin
               $display("rx word %h ok", data_out);
            end
         end
      end
   end

   task automatic send_level(input logic lvl, input int n);
      if (lvl !== cur_lvl) exp_edges++;
      cur_lvl = lvl;
      I_P = lvl;
      I_N = ~lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // abort: 0 none, 1 en low for one cycle mid data bit 0, 2 rst for one cycle there
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int abort);
      if (abort == 0 && stop_bit) exp_q.push_back(d);
      send_level(1'b0, BIT_CYC);
      if (abort == 0) begin
         send_level(d[0], BIT_CYC);
      end else begin
         send_level(d[0], BIT_CYC / 2);
         if (abort == 1) begin
            en = 1'b0;
            @(negedge clk);
            en = 1'b1;
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL en_abort_busy: busy=%b, required 0", busy);
            end
         end else begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            exp_edges = 0;
            checks += 2;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL rst_abort_busy: busy=%b, required 0", busy);
            end
            if (data_out !== 8'h00 || edge_cnt !== 16'd0) begin
               errors++;
               $display("FAIL rst_abort_regs: data_out=%h edge_cnt=%0d, required 00 and 0", data_out, edge_cnt);
            end
         end
         send_level(d[0], BIT_CYC / 2 - 1);
      end
      for (int i = 1; i < 8; i++) send_level(d[i], BIT_CYC);
      send_level(stop_bit, BIT_CYC);
      send_level(1'b1, 12);
      $display("frame %h stop=%b abort=%0d sent", d, stop_bit, abort);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; start = 1'b0; I_P = 1'b1; I_N = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks += 3;
      if (data_out !== 8'h00 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: data_out=%h valid=%b, required 00 and 0", data_out, data_valid);
      end
      if (busy !== 1'b0 || frame_err !== 1'b0 || line_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b frame_err=%b line_err=%b, required 0 0 0", busy, frame_err, line_err);
      end
      if (edge_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_edges: edge_cnt=%0d, required 0", edge_cnt);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (edge_cnt !== 16'd0 || line_err !== 1'b0) begin
         errors++;
         $display("FAIL idle_quiet: edge_cnt=%0d line_err=%b, required 0 and 0", edge_cnt, line_err);
      end
      $display("reset checked");
   endtask

   task automatic test_frame();
      pulse_start();
      repeat (4) @(negedge clk);
      send_frame(8'hA5, 1'b1, 0);
      checks += 3;
      if (frame_err !== 1'b0) begin
         errors++;
         $display("FAIL frame_ok_err: frame_err=%b, required 0", frame_err);
      end
      if (edge_cnt !== 16'(exp_edges)) begin
         errors++;
         $display("FAIL frame_edges: edge_cnt=%0d, required %0d", edge_cnt, exp_edges);
      end
      if (exp_q.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_done: pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
      end
   endtask

   task automatic test_glitch();
      pulse_start();
      repeat (3) @(negedge clk);
      I_P = 1'b0; I_N = 1'b1;
      repeat (2) @(negedge clk);
      I_P = 1'b1; I_N = 1'b0;
      repeat (12) @(negedge clk);
      checks += 2;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL glitch_arm: busy=%b, required 1", busy);
      end
      if (edge_cnt !== 16'(exp_edges)) begin
         errors++;
         $display("FAIL glitch_edges: edge_cnt=%0d, required %0d", edge_cnt, exp_edges);
      end
      $display("glitch checked");
   endtask

   task automatic test_frame_err();
      send_frame(8'h3C, 1'b0, 0);
      checks += 3;
      if (frame_err !== 1'b1) begin
         errors++;
         $display("FAIL frame_err_set: frame_err=%b, required 1", frame_err);
      end
      if (data_out !== 8'hA5 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL frame_err_hold: data_out=%h pending=%0d, required a5 and 0", data_out, exp_q.size());
      end
      if (edge_cnt !== 16'(exp_edges)) begin
         errors++;
         $display("FAIL frame_err_edges: edge_cnt=%0d, required %0d", edge_cnt, exp_edges);
      end
      pulse_start();
      checks++;
      if (frame_err !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL frame_err_clear: frame_err=%b busy=%b, required 0 and 1", frame_err, busy);
      end
   endtask

   task automatic test_line_err();
      I_N = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 4) I_N = 1'b0;
         if (k == 5) begin
            checks++;
            if (line_err !== 1'b0) begin
               errors++;
               $display("FAIL line_err_early: line_err=%b at cycle 5, required 0", line_err);
            end
         end
         if (k == 6) begin
            checks++;
            if (line_err !== 1'b1) begin
               errors++;
               $display("FAIL line_err_set: line_err=%b at cycle 6, required 1", line_err);
            end
         end
      end
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      pulse_start();
      checks++;
      if (line_err !== 1'b0) begin
         errors++;
         $display("FAIL line_err_clear: line_err=%b, required 0", line_err);
      end
      I_N = 1'b1;
      repeat (3) @(negedge clk);
      I_N = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (line_err !== 1'b0) begin
         errors++;
         $display("FAIL line_err_short: line_err=%b after 3 equal cycles, required 0", line_err);
      end
      $display("line error checked");
   endtask

   task automatic test_abort();
      send_frame(8'hA5, 1'b1, 1);
      pulse_start();
      send_frame(8'h01, 1'b1, 0);
      pulse_start();
      send_frame(8'hA5, 1'b1, 2);
      pulse_start();
      send_frame(8'h01, 1'b1, 0);
      checks += 2;
      if (exp_q.size() != 0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL abort_done: pending=%0d frame_err=%b, required 0 and 0", exp_q.size(), frame_err);
      end
      if (edge_cnt !== 16'(exp_edges)) begin
         errors++;
         $display("FAIL abort_edges: edge_cnt=%0d, required %0d", edge_cnt, exp_edges);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_glitch();
      test_frame_err();
      test_line_err();
      test_abort();
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
